// File: rtl/systolic_pe_array_pkg.sv
// Shared types and helpers for the weight-stationary systolic MAC grid.
package systolic_pe_array_pkg;

  localparam int SYS_N     = 4;
  localparam int SYS_WIDTH = 16;

  function automatic int acc_width(input int width, input int n);
    return 2 * width + $clog2(n);
  endfunction

  localparam int SYS_ACC_W = acc_width(SYS_WIDTH, SYS_N);

  typedef struct packed {
    logic signed [SYS_WIDTH-1:0] act;
    logic                        valid;
  } pe_link_t;

  // Clamp a wide signed value into the signed range of 'width' bits.
  function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] acc,
                                                      input int width);
    logic signed [63:0] hi_v;
    logic signed [63:0] lo_v;
    hi_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo_v = -(64'sd1 <<< (width - 1));
    if (acc > hi_v) begin
      return hi_v;
    end else if (acc < lo_v) begin
      return lo_v;
    end else begin
      return acc;
    end
  endfunction

endpackage

// File: rtl/systolic_pe_array_pe.sv
// One MAC cell: activation moves right, partial sum moves down, weight stays put.
module systolic_pe
  import systolic_pe_array_pkg::*;
#(
  parameter int WIDTH = SYS_WIDTH,
  parameter int ACC_W = SYS_ACC_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    weight_load_i,
  input  logic signed [WIDTH-1:0] weight_i,
  input  pe_link_t                link_i,
  input  logic signed [ACC_W-1:0] psum_i,
  output pe_link_t                link_o,
  output logic signed [ACC_W-1:0] psum_o
);

  pe_link_t                  link_q;
  logic signed [WIDTH-1:0]   weight_q;
  logic signed [ACC_W-1:0]   psum_q;
  logic signed [ACC_W-1:0]   psum_d;
  logic [2*WIDTH-1:0]        act_ext_s;
  logic [2*WIDTH-1:0]        w_ext_s;
  logic [2*WIDTH-1:0]        prod_s;

  // Full-precision product, sign-extended into the accumulator; invalid lanes add nothing.
  always_comb begin
    act_ext_s = {{WIDTH{link_i.act[WIDTH-1]}}, link_i.act};
    w_ext_s   = {{WIDTH{weight_q[WIDTH-1]}}, weight_q};
    prod_s    = act_ext_s * w_ext_s;
    if (link_i.valid) begin
      psum_d = psum_i + {{(ACC_W-2*WIDTH){prod_s[2*WIDTH-1]}}, prod_s};
    end else begin
      psum_d = psum_i;
    end
  end

  // Pipeline registers and the stationary weight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      link_q   <= '0;
      weight_q <= '0;
      psum_q   <= '0;
    end else begin
      link_q <= link_i;
      psum_q <= psum_d;
      if (weight_load_i) begin
        weight_q <= weight_i;
      end
    end
  end

  assign link_o = link_q;
  assign psum_o = psum_q;

endmodule

// File: rtl/systolic_pe_array.sv
// NxN weight-stationary grid computing C = A x B; skewed A rows in, aligned C rows out
// after exactly 2N-1 cycles.
module systolic_pe_array
  import systolic_pe_array_pkg::*;
#(
  parameter int N     = SYS_N,
  parameter int WIDTH = SYS_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             weight_load,
  input  logic [N-1:0][N-1:0][WIDTH-1:0]   weight_in,
  input  logic [N-1:0][WIDTH-1:0]          data_up,
  input  logic [N-1:0]                     enable,
  output logic [N-1:0][WIDTH-1:0]          result_col,
  output logic                             result_valid,
  output logic [7:0]                       result_row,
  output logic                             busy,
  output logic                             load_err
);

  localparam int ACC_W = acc_width(WIDTH, N);
  localparam int VLD_D = 2 * N - 1;

  pe_link_t                  link_s [N][N];
  logic signed [ACC_W-1:0]   psum_s [N][N];
  logic [N*N-1:0]            pe_valid_s;
  logic [N-1:0][WIDTH-1:0]   live_s;
  logic [N-1:0][WIDTH-1:0]   hold_q;
  logic [VLD_D-1:0]          vld_q;
  logic [7:0]                row_q;
  logic                      load_err_q;
  logic                      busy_s;
  logic                      load_ok_s;

  assign busy_s    = (|pe_valid_s) | (|vld_q);
  assign load_ok_s = weight_load & ~busy_s;

  for (genvar k = 0; k < N; k++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      pe_link_t                lin_s;
      logic signed [ACC_W-1:0] pin_s;

      if (j == 0) begin : g_edge
        assign lin_s.act   = data_up[k];
        assign lin_s.valid = enable[k];
      end else begin : g_inner
        assign lin_s = link_s[k][j-1];
      end

      if (k == 0) begin : g_top
        assign pin_s = '0;
      end else begin : g_below
        assign pin_s = psum_s[k-1][j];
      end

      systolic_pe #(
        .WIDTH (WIDTH),
        .ACC_W (ACC_W)
      ) u_pe (
        .clk           (clk),
        .rst           (rst),
        .weight_load_i (load_ok_s),
        .weight_i      (weight_in[j][k]),
        .link_i        (lin_s),
        .psum_i        (pin_s),
        .link_o        (link_s[k][j]),
        .psum_o        (psum_s[k][j])
      );

      assign pe_valid_s[k*N+j] = link_s[k][j].valid;
    end
  end

  // Column j leaves the grid j cycles after column 0, so it gets N-1-j delay stages.
  for (genvar j = 0; j < N; j++) begin : g_dsk
    localparam int D = N - 1 - j;
    logic signed [ACC_W-1:0] col_s;
    logic signed [63:0]      wide_s;

    if (D == 0) begin : g_pass
      assign col_s = psum_s[N-1][j];
    end else begin : g_regs
      logic signed [ACC_W-1:0] dq [D];

      // De-skew delay line for this column.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int s = 0; s < D; s++) begin
            dq[s] <= '0;
          end
        end else begin
          dq[0] <= psum_s[N-1][j];
          for (int s = 1; s < D; s++) begin
            dq[s] <= dq[s-1];
          end
        end
      end

      assign col_s = dq[D-1];
    end

    assign wide_s    = 64'(col_s);
    assign live_s[j] = WIDTH'(sat_to_width(wide_s, WIDTH));
  end

  // Row-valid tracking, row index, held output row and sticky load hazard flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q      <= '0;
      row_q      <= 8'd0;
      hold_q     <= '0;
      load_err_q <= 1'b0;
    end else begin
      vld_q <= {vld_q[VLD_D-2:0], enable[0]};
      if (weight_load && busy_s) begin
        load_err_q <= 1'b1;
      end
      if (!busy_s) begin
        row_q <= 8'd0;
      end else if (vld_q[VLD_D-1]) begin
        row_q <= row_q + 8'd1;
      end
      if (vld_q[VLD_D-1]) begin
        hold_q <= live_s;
      end
    end
  end

  assign result_valid = vld_q[VLD_D-1];
  assign result_col   = result_valid ? live_s : hold_q;
  assign result_row   = row_q;
  assign busy         = busy_s;
  assign load_err     = load_err_q;

endmodule

// File: tb/tb_systolic_pe_array.sv
// Directed bench for systolic_pe_array: identity, signed/saturating products, load hazard,
// partial lane use and mid-stream reset, with hand-computed expected rows.
module tb_systolic_pe_array;

  logic                   clk;
  logic                   rst;
  logic                   weight_load;
  logic [3:0][3:0][15:0]  weight_in;
  logic [3:0][15:0]       data_up;
  logic [3:0]             enable;
  logic [3:0][15:0]       result_col;
  logic                   result_valid;
  logic [7:0]             result_row;
  logic                   busy;
  logic                   load_err;

  logic signed [15:0]     a_m   [4][4];
  logic signed [15:0]     b_m   [4][4];
  logic signed [15:0]     exp_m [4][4];
  logic [3:0][3:0][15:0]  ident_w;

  int total_cnt = 0;
  int bad_cnt   = 0;

  systolic_pe_array #(.N(4), .WIDTH(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .weight_load  (weight_load),
    .weight_in    (weight_in),
    .data_up      (data_up),
    .enable       (enable),
    .result_col   (result_col),
    .result_valid (result_valid),
    .result_row   (result_row),
    .busy         (busy),
    .load_err     (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp_v);
    total_cnt++;
    if (got != exp_v) begin
      bad_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp_v);
    end
  endtask

  function automatic longint col_val(input int j);
    return longint'($signed(result_col[j]));
  endfunction

  task automatic load_weights();
    @(negedge clk);
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 4; j++)
        weight_in[j][k] = b_m[k][j];
    weight_load = 1'b1;
    @(negedge clk);
    weight_load = 1'b0;
  endtask

  // Lane k carries row t-k of A; lanes at or above 'lanes' present data but are not enabled.
  task automatic drive_inputs(input int t, input int rows, input int lanes);
    for (int k = 0; k < 4; k++) begin
      if (t - k >= 0 && t - k < rows) begin
        data_up[k] = a_m[t-k][k];
        enable[k]  = (k < lanes);
      end else begin
        data_up[k] = 16'd0;
        enable[k]  = 1'b0;
      end
    end
  endtask

  task automatic run_stream(input int rows, input int lanes, input int wl_t);
    for (int t = 0; t <= rows + 10; t++) begin
      @(negedge clk);
      if (t == 0) chk("busy_idle", busy, 0);
      if (t == 1) chk("busy_run", busy, 1);
      if (t >= 7 && t - 7 < rows) begin
        chk("valid", result_valid, 1);
        chk("row", result_row, t - 7);
        for (int j = 0; j < 4; j++)
          chk($sformatf("r%0d_col%0d", t - 7, j), col_val(j), exp_m[t-7][j]);
      end else begin
        chk($sformatf("valid_lo_t%0d", t), result_valid, 0);
      end
      drive_inputs(t, rows, lanes);
      if (t == wl_t) begin
        weight_in   = ident_w;
        weight_load = 1'b1;
      end else begin
        weight_load = 1'b0;
      end
    end
    @(negedge clk);
    chk("busy_end", busy, 0);
    chk("row_end", result_row, 0);
    for (int j = 0; j < 4; j++)
      chk($sformatf("hold_col%0d", j), col_val(j), exp_m[rows-1][j]);
  endtask

  initial begin
    rst         = 1'b0;
    weight_load = 1'b0;
    weight_in   = '0;
    data_up     = '0;
    enable      = 4'b0000;
    ident_w     = '0;
    for (int i = 0; i < 4; i++) ident_w[i][i] = 16'd1;

    repeat (2) @(negedge clk);
    chk("rst_valid", result_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_load_err", load_err, 0);
    chk("rst_row", result_row, 0);
    for (int j = 0; j < 4; j++) chk($sformatf("rst_col%0d", j), col_val(j), 0);
    rst = 1'b1;

    // Identity weights: output rows equal the input rows.
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 4; j++)
        b_m[k][j] = (k == j) ? 16'sd1 : 16'sd0;
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++) begin
        a_m[r][k]   = 16'(4 * r + k + 1);
        exp_m[r][k] = 16'(4 * r + k + 1);
      end
    load_weights();
    run_stream(4, 4, -1);
    chk("load_err_clean", load_err, 0);

    // Signed products with saturation; a load pulse lands mid-stream and must be refused.
    b_m   = '{'{-16'sd1,  16'sd2,  16'sd0, 16'sh8000},
              '{ 16'sd3, -16'sd1,  16'sd4,  16'sd1},
              '{ 16'sd0,  16'sd5, -16'sd2,  16'sd2},
              '{ 16'sd7,  16'sd0,  16'sd1, -16'sd1}};
    a_m   = '{'{ 16'sd1, -16'sd2,  16'sd3,  16'sd0},
              '{-16'sd1,  16'sd0,  16'sd2, -16'sd3},
              '{ 16'sd32767, 16'sd0, 16'sd0, 16'sd0},
              '{ 16'sd0, -16'sd1, -16'sd1,  16'sd1}};
    exp_m = '{'{-16'sd7,  16'sd19, -16'sd14, -16'sd32764},
              '{-16'sd20, 16'sd8,  -16'sd7,   16'sd32767},
              '{-16'sd32767, 16'sd32767, 16'sd0, 16'sh8000},
              '{ 16'sd4, -16'sd4, -16'sd1, -16'sd4}};
    load_weights();
    run_stream(4, 4, 2);
    chk("load_err_set", load_err, 1);

    // Positive saturation, loaded while idle.
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++) begin
        a_m[r][k]   = 16'sd32767;
        b_m[r][k]   = 16'sd32767;
        exp_m[r][k] = 16'sd32767;
      end
    load_weights();
    run_stream(2, 4, -1);
    chk("load_err_sticky", load_err, 1);

    // Negative saturation.
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++) begin
        a_m[r][k]   = 16'sh8000;
        exp_m[r][k] = 16'sh8000;
      end
    run_stream(2, 4, -1);

    // Two active lanes; disabled lanes carry garbage against large weights.
    b_m   = '{'{16'sd2, -16'sd3, 16'sd0, 16'sd0},
              '{16'sd4,  16'sd5, 16'sd0, 16'sd0},
              '{16'sd500, 16'sd500, 16'sd500, 16'sd500},
              '{16'sd500, 16'sd500, 16'sd500, 16'sd500}};
    a_m   = '{'{ 16'sd1, 16'sd2,  16'sd1000, -16'sd999},
              '{-16'sd3, 16'sd4, -16'sd999,   16'sd1000},
              '{ 16'sd0, 16'sd0,  16'sd0,     16'sd0},
              '{ 16'sd0, 16'sd0,  16'sd0,     16'sd0}};
    exp_m = '{'{16'sd10, 16'sd7,  16'sd0, 16'sd0},
              '{16'sd10, 16'sd29, 16'sd0, 16'sd0},
              '{16'sd0,  16'sd0,  16'sd0, 16'sd0},
              '{16'sd0,  16'sd0,  16'sd0, 16'sd0}};
    load_weights();
    run_stream(2, 2, -1);

    // Reset three cycles into a four-row stream.
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      drive_inputs(t, 4, 4);
    end
    @(negedge clk);
    drive_inputs(3, 4, 4);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_valid", result_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_row", result_row, 0);
    chk("mid_rst_load_err", load_err, 0);
    for (int j = 0; j < 4; j++) chk($sformatf("mid_rst_col%0d", j), col_val(j), 0);
    data_up = '0;
    enable  = 4'b0000;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      chk($sformatf("post_rst_valid_t%0d", t), result_valid, 0);
      chk($sformatf("post_rst_busy_t%0d", t), busy, 0);
    end
    chk("post_rst_col0", col_val(0), 0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
